// File: rtl/vx_hamming_dec.sv
// Two-stage pipelined SECDED decoder for extended-Hamming codewords on the cache read-return path.
// Optional saturating error counters are enabled with `define VX_HAMMING_DEC_CNT_EN.
module vx_hamming_dec #(
    parameter int unsigned DATA_BITS    = 15,
    parameter int unsigned HAMMING_BITS =
        ((1 << 2) >= DATA_BITS + 3)  ? 2 :
        ((1 << 3) >= DATA_BITS + 4)  ? 3 :
        ((1 << 4) >= DATA_BITS + 5)  ? 4 :
        ((1 << 5) >= DATA_BITS + 6)  ? 5 :
        ((1 << 6) >= DATA_BITS + 7)  ? 6 :
        ((1 << 7) >= DATA_BITS + 8)  ? 7 :
        ((1 << 8) >= DATA_BITS + 9)  ? 8 :
        ((1 << 9) >= DATA_BITS + 10) ? 9 : 10,
    parameter int unsigned ENCODED_BITS = DATA_BITS + HAMMING_BITS + 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [ENCODED_BITS-1:0] encoded_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_BITS-1:0]    data_out,
    output logic                    err_corrected,
    output logic                    err_double,
    output logic [HAMMING_BITS-1:0] syndrome_out
`ifdef VX_HAMMING_DEC_CNT_EN
    ,
    input  logic                    cnt_clear,
    output logic [CNT_WIDTH-1:0]    cnt_corrected,
    output logic [CNT_WIDTH-1:0]    cnt_double
`endif
);

    if (DATA_BITS == 0 || CNT_WIDTH == 0) begin : g_param_check
        $error("vx_hamming_dec: DATA_BITS and CNT_WIDTH must be non-zero");
    end

    // Highest Hamming position number; a larger syndrome cannot be a single-bit error.
    localparam logic [HAMMING_BITS-1:0] MAX_POS = HAMMING_BITS'(ENCODED_BITS - 1);

    logic stall;

    // Stage 1 state
    logic                    s1_valid_q;
    logic [ENCODED_BITS-1:0] s1_code_q;
    logic [HAMMING_BITS-1:0] s1_syn_q;
    logic                    s1_par_q;

    // Stage 2 state
    logic                    valid_q;
    logic [DATA_BITS-1:0]    data_q;
    logic                    corr_q;
    logic                    dbl_q;
    logic [HAMMING_BITS-1:0] syn_q;

    logic [HAMMING_BITS-1:0] syn_d;
    logic                    par_d;
    logic [ENCODED_BITS-1:0] fixed;
    logic [DATA_BITS-1:0]    data_d;
    logic                    corr_d;
    logic                    dbl_d;

    assign stall    = valid_q & ~ready_out;
    assign ready_in = ~stall;

    always_comb begin
        syn_d = '0;
        for (int i = 0; i < ENCODED_BITS - 1; i++) begin
            for (int k = 0; k < HAMMING_BITS; k++) begin
                if (((i + 1) >> k) % 2 == 1) begin
                    syn_d[k] = syn_d[k] ^ encoded_in[i];
                end
            end
        end
        par_d = ^encoded_in;
    end

    always_comb begin
        int j;
        fixed  = s1_code_q;
        corr_d = 1'b0;
        dbl_d  = 1'b0;
        data_d = '0;
        j      = 0;
        if (s1_syn_q == '0) begin
            // Zero syndrome with odd parity means only the overall parity bit flipped.
            corr_d = s1_par_q;
        end else if (s1_par_q && (s1_syn_q <= MAX_POS)) begin
            corr_d = 1'b1;
            for (int i = 0; i < ENCODED_BITS - 1; i++) begin
                if (s1_syn_q == HAMMING_BITS'(i + 1)) begin
                    fixed[i] = ~fixed[i];
                end
            end
        end else begin
            dbl_d = 1'b1;
        end
        for (int i = 0; i < ENCODED_BITS - 1; i++) begin
            if ((((i + 1) & i) != 0) && (j < DATA_BITS)) begin
                data_d[j] = fixed[i];
                j = j + 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            corr_q     <= 1'b0;
            dbl_q      <= 1'b0;
            syn_q      <= '0;
        end else if (!stall) begin
            s1_valid_q <= valid_in;
            s1_code_q  <= encoded_in;
            s1_syn_q   <= syn_d;
            s1_par_q   <= par_d;
            valid_q    <= s1_valid_q;
            data_q     <= data_d;
            corr_q     <= corr_d;
            dbl_q      <= dbl_d;
            syn_q      <= s1_syn_q;
        end
    end

    assign valid_out     = valid_q;
    assign data_out      = data_q;
    assign err_corrected = corr_q;
    assign err_double    = dbl_q;
    assign syndrome_out  = syn_q;

`ifdef VX_HAMMING_DEC_CNT_EN
    logic                 out_fire;
    logic [CNT_WIDTH-1:0] cnt_corr_q;
    logic [CNT_WIDTH-1:0] cnt_dbl_q;

    assign out_fire = valid_q & ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_corr_q <= '0;
            cnt_dbl_q  <= '0;
        end else if (cnt_clear) begin
            cnt_corr_q <= '0;
            cnt_dbl_q  <= '0;
        end else begin
            if (out_fire && corr_q && (cnt_corr_q != '1)) begin
                cnt_corr_q <= cnt_corr_q + 1'b1;
            end
            if (out_fire && dbl_q && (cnt_dbl_q != '1)) begin
                cnt_dbl_q <= cnt_dbl_q + 1'b1;
            end
        end
    end

    assign cnt_corrected = cnt_corr_q;
    assign cnt_double    = cnt_dbl_q;
`endif

endmodule

// File: tb/tb_vx_hamming_dec.sv
// Scoreboard bench for vx_hamming_dec: randomized codewords with 0-2 flipped bits, backpressure,
// mid-flight reset, and (with VX_HAMMING_DEC_CNT_EN) the saturating counters at CNT_WIDTH=2.
module tb_vx_hamming_dec;

    localparam int D  = 15;
    localparam int H  = 5;
    localparam int E  = 21;
    localparam int CW = 2;

    typedef struct packed {
        logic [D-1:0] data;
        logic         corr;
        logic         dbl;
        logic [H-1:0] syn;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic [E-1:0] encoded_in = '0;
    logic         valid_out;
    logic         ready_out = 1'b1;
    logic [D-1:0] data_out;
    logic         err_corrected;
    logic         err_double;
    logic [H-1:0] syndrome_out;
`ifdef VX_HAMMING_DEC_CNT_EN
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] cnt_corrected;
    logic [CW-1:0] cnt_double;
`endif

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    bit   a_done = 0;

    vx_hamming_dec #(.DATA_BITS(15), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .encoded_in   (encoded_in),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .err_corrected(err_corrected),
        .err_double   (err_double),
        .syndrome_out (syndrome_out)
`ifdef VX_HAMMING_DEC_CNT_EN
        ,
        .cnt_clear    (cnt_clear),
        .cnt_corrected(cnt_corrected),
        .cnt_double   (cnt_double)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: positions are numbered 1..E-1, powers of two hold check bits.
    function automatic int syn_of(logic [E-1:0] r);
        int s = 0;
        for (int pos = 1; pos < E; pos++) if (r[pos-1]) s = s ^ pos;
        return s;
    endfunction

    function automatic logic [D-1:0] extract(logic [E-1:0] r);
        logic [D-1:0] d = '0;
        int j = 0;
        for (int pos = 1; pos < E; pos++) begin
            if ($countones(pos) != 1) begin
                d[j] = r[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [E-1:0] encode(logic [D-1:0] d);
        logic [E-1:0] c = '0;
        int j = 0;
        int s = 0;
        for (int pos = 1; pos < E; pos++) begin
            if ($countones(pos) != 1) begin
                c[pos-1] = d[j];
                if (d[j]) s = s ^ pos;
                j++;
            end
        end
        for (int k = 0; k < H; k++) c[(1 << k) - 1] = s[k];
        c[E-1] = ^c[E-2:0];
        return c;
    endfunction

    // d is the payload originally encoded; r is the codeword as received (at most two flips).
    function automatic exp_t make_exp(logic [D-1:0] d, logic [E-1:0] r);
        exp_t e;
        int   s;
        bit   p;
        s      = syn_of(r);
        p      = ^r;
        e.syn  = s[H-1:0];
        e.corr = 1'b0;
        e.dbl  = 1'b0;
        e.data = d;
        if (s == 0 && !p) begin
            e.corr = 1'b0;
        end else if (p && s <= E - 1) begin
            e.corr = 1'b1;
        end else begin
            e.dbl  = 1'b1;
            e.data = extract(r);
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && valid_out && ready_out) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output: got data %0h, required no output", data_out);
            end else begin
                exp_t e;
                exp_t got;
                e   = sb.pop_front();
                got = {data_out, err_corrected, err_double, syndrome_out};
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL output: got data=%0h corr=%0b dbl=%0b syn=%0d, required data=%0h corr=%0b dbl=%0b syn=%0d",
                             data_out, err_corrected, err_double, syndrome_out,
                             e.data, e.corr, e.dbl, e.syn);
                end
            end
        end
    end

    task automatic send(logic [E-1:0] code, exp_t e);
        int n = 0;
        valid_in   = 1'b1;
        encoded_in = code;
        @(negedge clk);
        while (!ready_in && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) begin
            check("ready_in_timeout", 32'(ready_in), 32'd1);
            @(posedge clk);
        end else begin
            @(posedge clk);
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic send_word(logic [D-1:0] d, int nflip, int i0, int i1);
        logic [E-1:0] r;
        r = encode(d);
        if (nflip >= 1) r[i0] = ~r[i0];
        if (nflip >= 2) r[i1] = ~r[i1];
        send(r, make_exp(d, r));
    endtask

    task automatic send_random();
        int nf = $urandom_range(0, 2);
        int i0 = $urandom_range(0, E - 1);
        int i1 = $urandom_range(0, E - 2);
        if (i1 >= i0) i1++;
        send_word(D'($urandom), nf, i0, i1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", 32'(sb.size()), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [D-1:0] d;
        int t0;
        int n;

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_flags", 32'({err_corrected, err_double}), 32'd0);
        check("reset_syndrome", 32'(syndrome_out), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(ready_in), 32'd1);
        @(posedge clk);
        #1;

        // Latency: accepted at edge N, valid after edge N+1.
        send(E'(0), make_exp(D'(0), E'(0)));
        valid_in = 1'b0;
        check("latency_s1_not_valid", 32'(valid_out), 32'd0);
        @(posedge clk);
        #1;
        check("latency_s2_valid", 32'(valid_out), 32'd1);
        drain();

        // Single-bit flips: index 2 of zero word, then every index of a random word.
        send_word(D'(0), 1, 2, 0);
        d = D'($urandom);
        for (int i = 0; i < E; i++) send_word(d, 1, i, 0);
        send_word(D'(0), 1, 20, 0);
        send_word(D'(0), 2, 2, 4);
        valid_in = 1'b0;
        drain();

        // Backpressure: stall 3 cycles as soon as the first word emerges.
        fork
            begin
                for (int i = 0; i < 5; i++) send_random();
                valid_in = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!valid_out && n < 20);
                check("stall_first_valid", 32'(valid_out), 32'd1);
                ready_out = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("stall_ready_in", 32'(ready_in), 32'd0);
                    check("stall_valid_held", 32'(valid_out), 32'd1);
                    if (sb.size() != 0) check("stall_data_held", 32'(data_out), 32'(sb[0].data));
                    @(posedge clk);
                    #1;
                end
                ready_out = 1'b1;
            end
        join
        drain();

        // Full throughput: ten back-to-back accepts take ten cycles.
        t0 = cyc;
        for (int i = 0; i < 10; i++) send_random();
        valid_in = 1'b0;
        check("throughput_cycles", 32'(cyc - t0), 32'd10);
        drain();

        // Reset with two words in flight.
        send_random();
        send_random();
        valid_in = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset_valid_out", 32'(valid_out), 32'd0);
        check("midreset_data_out", 32'(data_out), 32'd0);
        check("midreset_flags", 32'({err_corrected, err_double}), 32'd0);
        check("midreset_syndrome", 32'(syndrome_out), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_ready_in", 32'(ready_in), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("midreset_no_ghost", 32'(valid_out), 32'd0);

        // Random traffic with random gaps and random backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_random();
                    if ($urandom_range(0, 3) == 0) begin
                        valid_in = 1'b0;
                        repeat ($urandom_range(1, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                valid_in = 1'b0;
                a_done = 1;
            end
            begin
                while (!a_done) begin
                    @(posedge clk);
                    #1;
                    ready_out = ($urandom_range(0, 3) != 0);
                end
                ready_out = 1'b1;
            end
        join
        drain();

`ifdef VX_HAMMING_DEC_CNT_EN
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        for (int i = 0; i < 5; i++) send_word(D'($urandom), 1, i, 0);
        valid_in = 1'b0;
        drain();
        check("cnt_corrected_saturate", 32'(cnt_corrected), 32'd3);
        check("cnt_double_idle", 32'(cnt_double), 32'd0);
        send_word(D'($urandom), 1, 7, 0);
        valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        check("cnt_clear_priority", 32'(cnt_corrected), 32'd0);
        send_word(D'($urandom), 2, 3, 9);
        valid_in = 1'b0;
        drain();
        check("cnt_double_one", 32'(cnt_double), 32'd1);
        check("cnt_corrected_after_dbl", 32'(cnt_corrected), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got still running, required finished");
        $fatal(1, "timeout");
    end

endmodule
